div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; executes DIV/DIVU.
- Raises `stallreq_o`, the EX-side stall request consumed by the pipeline stall controller, for as long as a division is outstanding.
- Returns quotient (LO) and remainder (HI) to EX, which writes them to HI/LO.
- Restoring radix-2 algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  EX holds this high for the whole division.
- annul_i  in  1  abort request (EX flushed).
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result_o is valid.
- stallreq_o  out  1  stall request to the stall controller.

Behaviour:
- Reset (rst=0 at an edge): state=FREE, cnt=0, result_o=0, ready_o=0, internal registers cleared.
- Reset mid-division aborts it; no partial result is ever presented.
- stallreq_o is combinational: start_i & ~ready_o. It is 0 whenever rst=0.
- FREE:
  - start_i=1 and annul_i=0: latch operands.
  - If signed_div_i=1, take magnitudes and record qneg = sign1^sign2 and rneg = sign1.
  - If divisor=0, go to BYZERO; otherwise go to ON with cnt=0 and partial remainder=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- ON, one iteration per edge:
  - trial = {rem[WIDTH-1:0], dividend MSB} - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial and quotient bit = 1. Otherwise shift only and quotient bit = 0.
  - cnt increments each iteration.
  - At the edge where cnt==WIDTH: apply sign fix-up (negate quotient if qneg, negate remainder if rneg), register result_o, set ready_o=1, go to END.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1. The ISA leaves this result undefined; the value is fixed at 0 so it is checkable.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: go to FREE, ready_o=0, result_o=0.
- annul_i=1 in ON or BYZERO: go to FREE at the next edge, ready_o=0, result discarded.
- annul_i in FREE: has priority over start_i (no start). annul_i in END: ignored.
- Latency, from the edge that samples start_i in FREE to ready_o=1:
  - WIDTH+2 edges (34 for WIDTH=32).
  - 2 edges for a zero divisor.
- Signed corner cases:
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - The magnitude of 0x80000000 is treated as unsigned 0x80000000.
- start_i dropping in ON without annul_i is illegal; it is asserted in the bench. Behaviour is as for annul_i.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- With the macro: in FREE, if the divisor is non-zero and the unsigned magnitude of the dividend is less than that of the divisor, go straight to END. Result is quotient 0 and remainder = opdata1_i unchanged, including sign; latency is 1 edge.
- Without the macro: every non-zero-divisor operation takes the full WIDTH+2 edges.
- Results are bit-identical either way.

Decomposition:
- Shared defines file holds:
  - state encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2 bits);
  - DIV_RESULT_READY / DIV_RESULT_NOT_READY;
  - DIV_START / DIV_STOP;
  - the reset-active level, 1'b0.
- No sub-module: the datapath is one subtract-and-shift. Keep the sign fix-up as a function inside div_unit.

Test Plan:
- Unsigned 100 / 7, start held:
  - stallreq_o=1 for 34 cycles;
  - then ready_o=1 and result_o={0x00000002, 0x0000000E};
  - stallreq_o drops in the same cycle.
- Signed -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divisor 0 (5 / 0) → ready_o=1 two edges after start, result_o=0. Drop start_i → FREE, ready_o=0.
- annul_i pulsed at iteration 10, then a new start 3 / 1 → the first operation leaves no result, and the second completes with {0, 3} after 34 edges.
- rst=0 during iteration 20 → next cycle ready_o=0, stallreq_o=0, result_o=0; a subsequent division is correct.
- Small dividend, 3 / 10, with DIV_EARLY_EXIT_EN:
  - with the macro: ready after 1 edge with {3, 0};
  - without it: ready after 34 edges with the same value.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider.
//
// Holds the 2-bit state encodings, the result-ready and start/stop levels,
// and the level on rst that means "in reset" (rst is active-low).
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic RST_ACTIVE           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for the EX stage (DIV/DIVU).
// One quotient bit is produced per clock; the pipeline is stalled through
// stallreq_o for as long as a division is outstanding.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous, active-low reset
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      held high by EX for the whole division
//   annul_i      abort request (EX flushed)
//   result_o     {remainder, quotient}
//   ready_o      result_o is valid
//   stallreq_o   stall request to the pipeline stall controller
//
// Optional build macro DIV_EARLY_EXIT_EN: when the dividend magnitude is
// smaller than the (non-zero) divisor magnitude, the answer is known at once
// (quotient 0, remainder = dividend) and the divider goes straight to END.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       dividend_q, dividend_d;
    logic [WIDTH-1:0]       divisor_q, divisor_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   ready_q, ready_d;

    logic [WIDTH-1:0]       mag1;
    logic [WIDTH-1:0]       mag2;
    logic [WIDTH:0]         trial;
    logic                   qbit;

    // Negate quotient and remainder back into signed form. The remainder
    // takes the sign of the dividend; 0x80000000 / -1 wraps to 0x80000000.
    function automatic logic [2*WIDTH-1:0] fix_sign(
        input logic [WIDTH-1:0] quot,
        input logic [WIDTH-1:0] rem,
        input logic             qneg,
        input logic             rneg
    );
        logic [WIDTH-1:0] q_fix;
        logic [WIDTH-1:0] r_fix;
        q_fix = qneg ? -quot : quot;
        r_fix = rneg ? -rem : rem;
        return {r_fix, q_fix};
    endfunction

    // Operand magnitudes; the most negative value maps to itself and is then
    // read as an unsigned number, which is exactly its magnitude.
    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The partial remainder is always below the divisor, so the top bit of
    // this (WIDTH+1)-bit difference is a reliable "went negative" flag.
    assign trial = {rem_q, dividend_q[WIDTH-1]} - {1'b0, divisor_q};

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = (rst != RST_ACTIVE) && start_i && !ready_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // The dividend register doubles as the quotient register: each iteration
    // shifts out a dividend bit at the top and shifts a quotient bit in at the
    // bottom, so after WIDTH iterations it holds the unsigned quotient.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;
        ready_d    = ready_q;
        qbit       = 1'b0;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    dividend_d = mag1;
                    divisor_d  = mag2;
                    qneg_d     = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_d     = signed_div_i && opdata1_i[WIDTH-1];
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (mag2 == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
`ifdef DIV_EARLY_EXIT_EN
                        if (mag1 < mag2) begin
                            state_d  = DIV_END;
                            ready_d  = DIV_RESULT_READY;
                            result_d = {opdata1_i, {WIDTH{1'b0}}};
                        end else begin
                            state_d = DIV_ON;
                        end
`else
                        state_d = DIV_ON;
`endif
                    end
                end
            end

            DIV_ON: begin
                // Losing start_i mid-division is treated like an annul.
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = fix_sign(dividend_q, rem_q, qneg_q, rneg_q);
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        qbit  = 1'b1;
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
                        qbit  = 1'b0;
                    end
                    dividend_d = {dividend_q[WIDTH-2:0], qbit};
                    cnt_d      = cnt_q + 1'b1;
                end
            end

            DIV_BYZERO: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = '0;
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signedDiv;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallReq;

   int checkCount;
   int failCount;
   bit busy;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .signed_div_i(signedDiv),
      .opdata1_i   (opA),
      .opdata2_i   (opB),
      .start_i     (start),
      .annul_i     (annul),
      .result_o    (result),
      .ready_o     (ready),
      .stallreq_o  (stallReq)
   );

   // 10-unit clock; inputs change on the falling edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount + 1);
      $fatal(1, "[TB] watchdog");
   end

   // The bench never drops start mid-division without annul
   always @(posedge clk) begin
      if (busy && rst && !start && !annul)
         $error("[TB] start dropped during a division without annul");
   end

   // Reference result: {remainder, quotient}, remainder takes the dividend's sign
   function automatic logic [63:0] refResult(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   // Reference latency in edges from the start edge to ready
   function automatic int refLatency(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      if (b == 32'd0) return 2;
      ma = s ? longint'($signed(a)) : longint'({32'd0, a});
      mb = s ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_EXIT_EN
      if (ma < mb) return 1;
`endif
      return 34;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Run one full division with start held, then release start
   task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
      int edges;
      int stallCycles;
      logic [63:0] expRes;
      int expLat;
      expRes = refResult(s, a, b);
      expLat = refLatency(s, a, b);
      @(negedge clk);
      signedDiv = s;
      opA = a;
      opB = b;
      annul = 1'b0;
      start = 1'b1;
      busy = 1'b1;
      #1;
      edges = 0;
      stallCycles = (stallReq === 1'b1) ? 1 : 0;
      while (ready !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (ready !== 1'b1 && stallReq === 1'b1) stallCycles++;
      end
      busy = 1'b0;
      checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
      checkOutput({tag, "_stall_cycles"}, 64'(stallCycles), 64'(expLat));
      checkOutput({tag, "_result"}, result, expRes);
      checkOutput({tag, "_stall_at_ready"}, {63'd0, stallReq}, 64'd0);
      // result must hold while start stays high
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold"}, {ready, result[62:0]}, {1'b1, expRes[62:0]});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_release"}, {63'd0, ready}, 64'd0);
      checkOutput({tag, "_release_res"}, result, 64'd0);
   endtask

   initial begin
      int mode;
      logic s;
      logic [31:0] a, b;
      checkCount = 0;
      failCount = 0;
      busy = 1'b0;
      rst = 1'b0;
      signedDiv = 1'b0;
      opA = 32'd100;
      opB = 32'd7;
      start = 1'b1;
      annul = 1'b0;

      // Reset with start asserted: everything held quiet
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", {63'd0, ready}, 64'd0);
      checkOutput("reset_result", result, 64'd0);
      checkOutput("reset_stall", {63'd0, stallReq}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk);

      // Directed cases
      applyStimulus("udiv_100_7", 1'b0, 32'd100, 32'd7);
      checkOutput("model_100_7", refResult(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      applyStimulus("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      applyStimulus("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus("div_by_zero", 1'b0, 32'd5, 32'd0);
      applyStimulus("small_3_10", 1'b0, 32'd3, 32'd10);
      applyStimulus("small_signed", 1'b1, 32'hFFFF_FFFD, 32'd10);

      // Annul at iteration 10, then a fresh division
      @(negedge clk);
      signedDiv = 1'b0;
      opA = 32'd1000;
      opB = 32'd3;
      start = 1'b1;
      busy = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      busy = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("annul_ready", {63'd0, ready}, 64'd0);
      checkOutput("annul_result", result, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("annul_idle", {63'd0, ready}, 64'd0);
      applyStimulus("after_annul_3_1", 1'b0, 32'd3, 32'd1);

      // Reset during iteration 20
      @(negedge clk);
      signedDiv = 1'b1;
      opA = 32'h7FFF_0000;
      opB = 32'd9;
      start = 1'b1;
      busy = 1'b1;
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      busy = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset_ready", {63'd0, ready}, 64'd0);
      checkOutput("midreset_stall", {63'd0, stallReq}, 64'd0);
      checkOutput("midreset_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk);
      applyStimulus("after_reset", 1'b1, 32'hFFFF_FC18, 32'd7);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         mode = $urandom_range(0, 5);
         case (mode)
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 100); end
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
            default: ;
         endcase
         applyStimulus($sformatf("rand%0d", i), s, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
